// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// PipeHazardCtrl: pipeline sequencing controller for the five-stage core.
//
// Every cycle it decides whether the PC advances, whether the F/D and D/E
// buffers load, and whether either buffer loads a bubble. It arbitrates
// between load-use hazards, taken branches resolved in Execute, multi-cycle
// memory stalls and HLT.
//
// Parameters
//   FLUSH_SLOTS  extra cycles F/D stays flushed after a taken branch (0..7)
//   CNT_W        width of the stall performance counter
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   d_src, d_dst      register addresses of the instruction in Decode
//   d_uses_src/dst    Decode instruction actually reads that register
//   e_mem_read        Execute instruction is a load
//   e_reg_write       Execute instruction writes a register
//   e_wa              Execute write address
//   ex_branch_taken   branch resolved taken in Execute this cycle
//   mem_busy          memory stage needs another cycle
//   halt_req          Decode holds HLT
//   resume            leave HALT
//   pc_en, fd_en, de_en    PC / F/D / D/E load enables
//   fd_flush, de_flush     F/D loads NOP / D/E loads bubble
//   state             RUN=0, FLUSH=1, MEM_WAIT=2, HALT=3
//   stall_cnt         saturating count of cycles with pc_en=0
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int FLUSH_SLOTS = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       d_src,
  input  logic [2:0]       d_dst,
  input  logic             d_uses_src,
  input  logic             d_uses_dst,
  input  logic             e_mem_read,
  input  logic             e_reg_write,
  input  logic [2:0]       e_wa,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             de_en,
  output logic             de_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [1:0] ST_HALT     = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       ret_q, ret_d;
  logic [2:0]       slot_q, slot_d;
  logic [CNT_W-1:0] stall_q;
  logic [1:0]       eff_state;
  logic             lu;

  // Load in Execute whose destination is read by the instruction in Decode.
  assign lu = e_mem_read & e_reg_write &
              ((d_uses_src & (d_src == e_wa)) | (d_uses_dst & (d_dst == e_wa)));

  // When a memory stall releases, this cycle behaves exactly like the state
  // that was interrupted, so decode against the saved return state.
  assign eff_state = ((state_q == ST_MEM_WAIT) && !mem_busy) ? ret_q : state_q;

  // Mealy output and next-state decode. Reset forces a fully drained,
  // frozen pipe regardless of what the other inputs say.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    slot_d   = slot_q;
    pc_en    = 1'b0;
    fd_en    = 1'b0;
    fd_flush = 1'b0;
    de_en    = 1'b0;
    de_flush = 1'b0;

    case (eff_state)
      ST_RUN: begin
        if (mem_busy) begin
          ret_d   = ST_RUN;
          state_d = ST_MEM_WAIT;
        end else if (ex_branch_taken) begin
          // Branch beats a simultaneous load-use: both younger instructions die.
          pc_en    = 1'b1;
          fd_en    = 1'b1;
          fd_flush = 1'b1;
          de_en    = 1'b1;
          de_flush = 1'b1;
          if (FLUSH_SLOTS > 0) begin
            state_d = ST_FLUSH;
            slot_d  = 3'(FLUSH_SLOTS);
          end
        end else if (lu) begin
          // Hold Fetch/Decode one cycle and push a single bubble into Execute.
          de_en    = 1'b1;
          de_flush = 1'b1;
        end else if (halt_req) begin
          // HLT itself moves on to Execute; nothing new is fetched behind it.
          fd_en    = 1'b1;
          fd_flush = 1'b1;
          de_en    = 1'b1;
          state_d  = ST_HALT;
        end else begin
          pc_en = 1'b1;
          fd_en = 1'b1;
          de_en = 1'b1;
        end
      end

      ST_FLUSH: begin
        if (mem_busy) begin
          ret_d   = ST_FLUSH;
          state_d = ST_MEM_WAIT;
        end else begin
          pc_en    = 1'b1;
          fd_en    = 1'b1;
          fd_flush = 1'b1;
          de_en    = 1'b1;
          slot_d   = slot_q - 3'd1;
          state_d  = (slot_q == 3'd1) ? ST_RUN : ST_FLUSH;
        end
      end

      ST_HALT: begin
        de_en    = 1'b1;
        de_flush = 1'b1;
        if (resume) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        // MEM_WAIT with mem_busy still high: everything frozen.
        state_d = ST_MEM_WAIT;
      end
    endcase

    if (rst) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_en    = 1'b0;
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end
  end

  // Registered control state; the stall counter saturates rather than wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      slot_q  <= 3'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      slot_q  <= slot_d;
      if (!pc_en && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_q;

endmodule
